// File: rtl/label_str_pkg.sv
// rtl/label_str_pkg.sv - shared constants, default label text and FSM states for label_str_buf
package label_str_pkg;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int N_DEFAULT = 4;
  localparam int DEFAULT_W = 8;

  // Text reads left to right, so character position 0 is the most significant byte.
  localparam logic [DEFAULT_W*8-1:0] DEFAULT_TEXT [0:N_DEFAULT-1] = '{
    "        ",
    "Pie     ",
    "Pesi    ",
    "7xi     "
  };

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STREAM
  } state_t;

  // One byte of the default row for label idx; anything outside the table is a space.
  function automatic logic [7:0] default_char(input int idx, input int pos);
    logic [DEFAULT_W*8-1:0] text;
    if (idx < 0 || idx >= N_DEFAULT || pos < 0 || pos >= DEFAULT_W) begin
      return CHAR_SPACE;
    end
    text = DEFAULT_TEXT[idx[1:0]];
    return 8'(text >> ((DEFAULT_W - 1 - pos) * 8));
  endfunction

endpackage

// File: rtl/label_row_ram.sv
// rtl/label_row_ram.sv - simple dual-port row RAM, byte-lane write enables, registered read-first port
module label_row_ram #(
  parameter int DEPTH  = 16,
  parameter int N_BYTE = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [N_BYTE-1:0]     wbe,
  input  logic [N_BYTE*8-1:0]   wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [N_BYTE*8-1:0]   rdata
);

  logic [N_BYTE*8-1:0] mem [DEPTH];

  // Contents are not reset; the owner rewrites every row after reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BYTE; b++) begin
      if (we && wbe[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/label_str_buf.sv
// rtl/label_str_buf.sv - runtime-writable label store streaming one label per request to the glyph renderer
module label_str_buf
  import label_str_pkg::*;
#(
  parameter int N_LABEL = 16,
  parameter int N_CHAR  = 8,
  parameter int TRIM    = 1,
  parameter int IDX_W   = $clog2(N_LABEL),
  parameter int POS_W   = $clog2(N_CHAR)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [POS_W-1:0] i_wr_pos,
  input  logic [7:0]       i_wr_char,
  output logic             o_wr_ready,
  input  logic             i_req_valid,
  input  logic [IDX_W-1:0] i_req_idx,
  output logic             o_req_ready,
  output logic             o_ch_valid,
  output logic [7:0]       o_ch_data,
  output logic [POS_W-1:0] o_ch_pos,
  output logic             o_ch_last,
  input  logic             i_ch_ready,
  output logic             o_init_done
);

  localparam int RAM_AW = $clog2(N_LABEL);
  localparam int LEN_W  = $clog2(N_CHAR + 1);
  localparam int ROW_W  = N_CHAR * 8;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] init_cnt;
  logic [IDX_W-1:0]  req_idx_q;
  logic              blank_q;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  rd_data;
  logic [ROW_W-1:0]  load_row;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  load_len;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [N_CHAR-1:0] ram_wbe;
  logic [ROW_W-1:0]  ram_wdata;
  logic              host_wr_ok;
  logic              req_fire;
  logic              beat_load;
  logic              beat_done;
  logic [POS_W-1:0]  next_pos;
  logic [7:0]        next_char;
  logic              next_last;

  assign o_wr_ready  = (state_q != ST_INIT);
  assign o_init_done = (state_q != ST_INIT);
  assign o_req_ready = (state_q == ST_IDLE);
  assign req_fire    = i_req_valid && o_req_ready;

  assign host_wr_ok = i_wr_en && o_wr_ready
                      && (int'(i_wr_idx) < N_LABEL) && (int'(i_wr_pos) < N_CHAR);

  // INIT owns the write port; afterwards the host writes a single byte lane.
  always_comb begin
    ram_we    = host_wr_ok;
    ram_waddr = i_wr_idx[RAM_AW-1:0];
    ram_wbe   = '0;
    ram_wbe[i_wr_pos] = 1'b1;
    ram_wdata = {N_CHAR{i_wr_char}};
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt;
      ram_wbe   = '1;
      for (int p = 0; p < N_CHAR; p++) begin
        ram_wdata[p*8 +: 8] = default_char(int'(init_cnt), p);
      end
    end
  end

  label_row_ram #(
    .DEPTH  (N_LABEL),
    .N_BYTE (N_CHAR),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata),
    .re    (state_q == ST_FETCH),
    .raddr (req_idx_q[RAM_AW-1:0]),
    .rdata (rd_data)
  );

  // Out-of-range requests never look at RAM data and stream a blank row instead.
  always_comb begin
    load_row = blank_q ? {N_CHAR{CHAR_SPACE}} : rd_data;
    load_len = LEN_W'(N_CHAR);
    if (TRIM != 0) begin
      load_len = LEN_W'(1);
      for (int p = 0; p < N_CHAR; p++) begin
        if (load_row[p*8 +: 8] != CHAR_SPACE) begin
          load_len = LEN_W'(p + 1);
        end
      end
    end
  end

  // Beats come from output registers: a new beat loads when the slot is empty or being accepted.
  always_comb begin
    next_pos  = o_ch_valid ? o_ch_pos + POS_W'(1) : '0;
    next_char = CHAR_SPACE;
    for (int p = 0; p < N_CHAR; p++) begin
      if (POS_W'(p) == next_pos) begin
        next_char = row_q[p*8 +: 8];
      end
    end
    next_last = (LEN_W'(next_pos) + LEN_W'(1)) == len_q;
    beat_load = (state_q == ST_STREAM) && (!o_ch_valid || (i_ch_ready && !o_ch_last));
    beat_done = (state_q == ST_STREAM) && o_ch_valid && i_ch_ready && o_ch_last;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (init_cnt == RAM_AW'(N_LABEL - 1)) state_d = ST_IDLE;
      ST_IDLE:   if (req_fire) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_STREAM;
      ST_STREAM: if (beat_done) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_cnt   <= '0;
      req_idx_q  <= '0;
      blank_q    <= 1'b0;
      row_q      <= '0;
      len_q      <= '0;
      o_ch_valid <= 1'b0;
      o_ch_data  <= '0;
      o_ch_pos   <= '0;
      o_ch_last  <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        init_cnt <= init_cnt + RAM_AW'(1);
      end
      if (req_fire) begin
        req_idx_q <= i_req_idx;
        blank_q   <= (int'(i_req_idx) >= N_LABEL);
      end
      if (state_q == ST_LOAD) begin
        row_q <= load_row;
        len_q <= load_len;
      end
      if (beat_load) begin
        o_ch_valid <= 1'b1;
        o_ch_pos   <= next_pos;
        o_ch_data  <= next_char;
        o_ch_last  <= next_last;
      end else if (beat_done) begin
        o_ch_valid <= 1'b0;
        o_ch_last  <= 1'b0;
      end
    end
  end

endmodule
